// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the
// fetch (IF) and data (MEM) pipeline ports.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_t;

    localparam logic [3:0] MEM_ALL_BYTES = 4'hF;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Serializes IF and data accesses onto the single-port memory: data wins,
// fetch is forced through after FETCH_MAX_WAIT consecutive losses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT        = 1,
    parameter int unsigned FETCH_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,

    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [3:0]  d_req_be,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,

    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 4 || FETCH_MAX_WAIT < 1 || FETCH_MAX_WAIT > 15) begin : g_bad_params
        $fatal(1, "mem_arbiter: MEM_LAT must be 1..4 and FETCH_MAX_WAIT 1..15");
    end

    localparam logic [1:0] LAT_LOAD   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(FETCH_MAX_WAIT);

    arb_state_t state, state_next;
    arb_owner_t owner, owner_next;
    logic [1:0] lat_cnt, lat_cnt_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       flushed, flushed_next;

    logic rsp_cycle, can_grant, fetch_forced, grant_d, grant_if, d_store;

    // The response cycle doubles as a grant slot so reads can be pipelined.
    assign rsp_cycle    = (state == ST_WAIT) && (lat_cnt == 2'd0);
    assign can_grant    = (state == ST_IDLE) || rsp_cycle;
    assign fetch_forced = if_req_valid && (starve_cnt == STARVE_MAX);
    assign grant_d      = can_grant && d_req_valid && !fetch_forced;
    assign grant_if     = can_grant && if_req_valid && !grant_d;
    assign d_store      = grant_d && d_req_we;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        if_req_ready = grant_if;
        d_req_ready  = grant_d;
        mem_en       = grant_d || grant_if;
        mem_we       = d_store;
        mem_be       = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        if (d_store) begin
            mem_be    = d_req_be;
            mem_wdata = d_req_wdata;
        end else if (mem_en) begin
            mem_be = MEM_ALL_BYTES;
        end
        if (grant_d) begin
            mem_addr = d_req_addr;
        end else if (grant_if) begin
            mem_addr = if_req_addr;
        end

        if_rsp_valid = rsp_cycle && (owner == OWN_IF) && !flushed && !if_flush;
        d_rsp_valid  = rsp_cycle && (owner == OWN_D);
        if_rsp_data  = if_rsp_valid ? mem_rdata : 32'h0;
        d_rsp_data   = d_rsp_valid  ? mem_rdata : 32'h0;
    end

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        lat_cnt_next = lat_cnt;
        flushed_next = flushed;
        if (can_grant) begin
            flushed_next = 1'b0;
            if (grant_if || (grant_d && !d_req_we)) begin
                state_next   = ST_WAIT;
                owner_next   = grant_if ? OWN_IF : OWN_D;
                lat_cnt_next = LAT_LOAD;
            end else begin
                state_next   = ST_IDLE;
                owner_next   = OWN_NONE;
                lat_cnt_next = 2'd0;
            end
        end else begin
            // Still waiting on memory: a flush only marks the read as dead.
            lat_cnt_next = lat_cnt - 2'd1;
            flushed_next = flushed || ((owner == OWN_IF) && if_flush);
        end

        if (!if_req_valid || grant_if) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt == STARVE_MAX) begin
            starve_cnt_next = starve_cnt;
        end else begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            lat_cnt    <= 2'd0;
            starve_cnt <= 4'd0;
            flushed    <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            lat_cnt    <= lat_cnt_next;
            starve_cnt <= starve_cnt_next;
            flushed    <= flushed_next;
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT = 1, 2, 3) share one stimulus set;
// each step checks the instance whose latency the scenario needs.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = 32'h0;
    logic        if_flush = 1'b0;
    logic        d_req_valid = 1'b0;
    logic        d_req_we = 1'b0;
    logic [3:0]  d_req_be = 4'h0;
    logic [31:0] d_req_addr = 32'h0;
    logic [31:0] d_req_wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;

    logic        if_req_ready [3];
    logic        if_rsp_valid [3];
    logic [31:0] if_rsp_data  [3];
    logic        d_req_ready  [3];
    logic        d_rsp_valid  [3];
    logic [31:0] d_rsp_data   [3];
    logic        mem_en       [3];
    logic        mem_we       [3];
    logic [3:0]  mem_be       [3];
    logic [31:0] mem_addr     [3];
    logic [31:0] mem_wdata    [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(.MEM_LAT(g + 1), .FETCH_MAX_WAIT(4)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .if_req_valid (if_req_valid),
            .if_req_addr  (if_req_addr),
            .if_req_ready (if_req_ready[g]),
            .if_flush     (if_flush),
            .if_rsp_valid (if_rsp_valid[g]),
            .if_rsp_data  (if_rsp_data[g]),
            .d_req_valid  (d_req_valid),
            .d_req_we     (d_req_we),
            .d_req_be     (d_req_be),
            .d_req_addr   (d_req_addr),
            .d_req_wdata  (d_req_wdata),
            .d_req_ready  (d_req_ready[g]),
            .d_rsp_valid  (d_rsp_valid[g]),
            .d_rsp_data   (d_rsp_data[g]),
            .mem_en       (mem_en[g]),
            .mem_we       (mem_we[g]),
            .mem_be       (mem_be[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        if_req_addr  = 32'h0;
        if_flush     = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_be     = 4'h0;
        d_req_addr   = 32'h0;
        d_req_wdata  = 32'h0;
        mem_rdata    = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        rst_n = 1'b0;
        sample();
        check("reset_if_ready",  32'(if_req_ready[1]), 32'd0);
        check("reset_mem_en",    32'(mem_en[1]),       32'd0);
        check("reset_mem_addr",  mem_addr[1],          32'h0);
        check("reset_d_rsp",     32'(d_rsp_valid[1]),  32'd0);
        check("reset_starve",    32'(g_dut[1].u_dut.starve_cnt), 32'd0);

        // 1: single fetch on MEM_LAT=2, followed back-to-back by a second one
        next_cycle();
        rst_n = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        sample();
        check("t1_if_ready_t",   32'(if_req_ready[1]), 32'd1);
        check("t1_mem_en_t",     32'(mem_en[1]),       32'd1);
        check("t1_mem_addr_t",   mem_addr[1],          32'h10);
        check("t1_mem_be_t",     32'(mem_be[1]),       32'hF);
        check("t1_mem_we_t",     32'(mem_we[1]),       32'd0);
        next_cycle();
        if_req_addr = 32'h14;
        sample();
        check("t1_if_ready_t1",  32'(if_req_ready[1]), 32'd0);
        check("t1_mem_en_t1",    32'(mem_en[1]),       32'd0);
        check("t1_rsp_t1",       32'(if_rsp_valid[1]), 32'd0);
        next_cycle();
        mem_rdata = 32'h00500313;
        sample();
        check("t1_rsp_t2",       32'(if_rsp_valid[1]), 32'd1);
        check("t1_rsp_data_t2",  if_rsp_data[1],       32'h00500313);
        check("t1_regrant_t2",   32'(if_req_ready[1]), 32'd1);
        check("t1_regrant_addr", mem_addr[1],          32'h14);
        check("t1_d_rsp_data",   d_rsp_data[1],        32'h0);
        next_cycle();
        idle_inputs();
        sample();
        check("t1_rsp_pulse",    32'(if_rsp_valid[1]), 32'd0);

        // 2: store then load on MEM_LAT=1
        do_reset();
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_be    = 4'b0011;
        d_req_addr  = 32'h100;
        d_req_wdata = 32'hDEADBEEF;
        sample();
        check("t2_st_ready",     32'(d_req_ready[0]),  32'd1);
        check("t2_st_we",        32'(mem_we[0]),       32'd1);
        check("t2_st_be",        32'(mem_be[0]),       32'h3);
        check("t2_st_addr",      mem_addr[0],          32'h100);
        check("t2_st_wdata",     mem_wdata[0],         32'hDEADBEEF);
        next_cycle();
        d_req_we = 1'b0;
        d_req_be = 4'h0;
        sample();
        check("t2_ld_ready",     32'(d_req_ready[0]),  32'd1);
        check("t2_ld_we",        32'(mem_we[0]),       32'd0);
        check("t2_ld_be",        32'(mem_be[0]),       32'hF);
        check("t2_st_no_rsp",    32'(d_rsp_valid[0]),  32'd0);
        next_cycle();
        d_req_valid = 1'b0;
        mem_rdata   = 32'h0000BEEF;
        sample();
        check("t2_ld_rsp",       32'(d_rsp_valid[0]),  32'd1);
        check("t2_ld_data",      d_rsp_data[0],        32'h0000BEEF);
        check("t2_if_data_zero", if_rsp_data[0],       32'h0);
        next_cycle();
        sample();
        check("t2_rsp_pulse",    32'(d_rsp_valid[0]),  32'd0);
        check("t2_rsp_data_off", d_rsp_data[0],        32'h0);

        // 3: contention, stores vs fetch, FETCH_MAX_WAIT=4 on MEM_LAT=1
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h80;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b1;
        d_req_be     = 4'hF;
        for (int i = 0; i < 4; i++) begin
            d_req_addr  = 32'h200 + 32'(4 * i);
            d_req_wdata = 32'(i);
            sample();
            check($sformatf("t3_d_win_%0d", i),  32'(d_req_ready[0]),  32'd1);
            check($sformatf("t3_if_lose_%0d", i), 32'(if_req_ready[0]), 32'd0);
            check($sformatf("t3_starve_%0d", i), 32'(g_dut[0].u_dut.starve_cnt), 32'(i));
            next_cycle();
        end
        sample();
        check("t3_if_forced",    32'(if_req_ready[0]), 32'd1);
        check("t3_d_blocked",    32'(d_req_ready[0]),  32'd0);
        check("t3_forced_addr",  mem_addr[0],          32'h80);
        check("t3_forced_we",    32'(mem_we[0]),       32'd0);
        next_cycle();
        if_req_valid = 1'b0;
        mem_rdata    = 32'hCAFE0001;
        sample();
        check("t3_if_rsp",       32'(if_rsp_valid[0]), 32'd1);
        check("t3_d_resumes",    32'(d_req_ready[0]),  32'd1);
        check("t3_starve_clear", 32'(g_dut[0].u_dut.starve_cnt), 32'd0);

        // 4: flush on MEM_LAT=3
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        sample();
        check("t4_accept",       32'(if_req_ready[2]), 32'd1);
        next_cycle();
        if_req_addr = 32'h44;
        if_flush    = 1'b1;
        sample();
        check("t4_busy_t1",      32'(if_req_ready[2]), 32'd0);
        next_cycle();
        if_flush = 1'b0;
        sample();
        check("t4_busy_t2",      32'(if_req_ready[2]), 32'd0);
        next_cycle();
        mem_rdata = 32'h12345678;
        sample();
        check("t4_rsp_killed",   32'(if_rsp_valid[2]), 32'd0);
        check("t4_data_killed",  if_rsp_data[2],       32'h0);
        check("t4_regrant",      32'(if_req_ready[2]), 32'd1);
        check("t4_regrant_addr", mem_addr[2],          32'h44);
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        mem_rdata = 32'h87654321;
        sample();
        check("t4_next_rsp",     32'(if_rsp_valid[2]), 32'd1);
        check("t4_next_data",    if_rsp_data[2],       32'h87654321);

        // 5: reset during an outstanding load on MEM_LAT=3
        do_reset();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h300;
        sample();
        check("t5_accept",       32'(d_req_ready[2]),  32'd1);
        next_cycle();
        idle_inputs();
        rst_n = 1'b0;
        sample();
        check("t5_rst_mem_en",   32'(mem_en[2]),       32'd0);
        check("t5_rst_d_ready",  32'(d_req_ready[2]),  32'd0);
        check("t5_rst_d_rsp",    32'(d_rsp_valid[2]),  32'd0);
        check("t5_rst_state",    32'(g_dut[2].u_dut.state), 32'(ST_IDLE));
        next_cycle();
        rst_n = 1'b1;
        mem_rdata = 32'hFFFF0000;
        sample();
        check("t5_no_rsp_t2",    32'(d_rsp_valid[2]),  32'd0);
        next_cycle();
        sample();
        check("t5_no_rsp_t3",    32'(d_rsp_valid[2]),  32'd0);
        check("t5_idle",         32'(g_dut[2].u_dut.state), 32'(ST_IDLE));
        next_cycle();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h304;
        sample();
        check("t5_grant_after",  32'(d_req_ready[2]),  32'd1);
        next_cycle();
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
